uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 32 +++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared package: FSM encoding and bit-timing helpers.
// Common to the receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RECV  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_PAYLOAD_DEF = 8;

  function automatic int cycles_per_bit(
    input int clk_hz,
    input int bit_rate
  );
    return clk_hz / bit_rate;
  endfunction

  function automatic int half_bit(
    input int clk_hz,
    input int bit_rate
  );
    return (clk_hz / bit_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// UART receive-side bundle: serial line, enable and
// received-frame outputs, with driver/receiver views.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = UART_PAYLOAD_DEF
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );

  modport slave (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_frame_err,
    output uart_rx_break
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB first, with
// frame-error and break detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BIT_RATE     = 256000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);
  localparam int CPB  = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HALF = half_bit(CLK_HZ, BIT_RATE);
  localparam int CW   = 1 + $clog2(CPB);
  localparam int BW   = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] CNT_BIT   = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e r_state;
  uart_state_e w_next;

  logic                    w_rxd_s;
  logic                    r_rxd_d;
  logic [CW-1:0]           r_cnt;
  logic [BW-1:0]           r_bits;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_lo_any;
  logic                    r_lo_all;
  logic                    r_valid;
  logic                    r_ferr;
  logic                    r_brk;

  logic w_fall;
  logic w_tick_half;
  logic w_tick_bit;
  logic w_last_bit;
  logic w_last_stop;
  logic w_end;
  logic w_lo_any;
  logic w_lo_all;
  logic w_ok;
  logic w_ferr;
  logic w_brk;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (uart_rxd),
    .o_q   (w_rxd_s)
  );

  assign w_fall      = r_rxd_d & ~w_rxd_s;
  assign w_tick_half = (r_cnt == CNT_HALF);
  assign w_tick_bit  = (r_cnt == CNT_BIT);
  assign w_last_bit  = (r_bits == LAST_BIT);
  assign w_last_stop = (r_bits == LAST_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && !uart_rx_en) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_fall && uart_rx_en) w_next = S_START;
        S_START:
          if (w_tick_half)
            w_next = w_rxd_s ? S_IDLE : S_RECV;
        S_RECV:
          if (w_tick_bit && w_last_bit) w_next = S_STOP;
        S_STOP:
          if (w_tick_bit && w_last_stop) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Frame outcome is decided on the last stop-sample edge.
  always_comb begin
    w_end    = (r_state == S_STOP) & uart_rx_en
             & w_tick_bit & w_last_stop;
    w_lo_any = r_lo_any | ~w_rxd_s;
    w_lo_all = r_lo_all & ~w_rxd_s;
    w_ok     = w_end & ~w_lo_any;
    w_ferr   = w_end & w_lo_any;
    w_brk    = w_end & w_lo_all & (r_shift == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_d  <= 1'b1;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_lo_any <= 1'b0;
      r_lo_all <= 1'b1;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_brk    <= 1'b0;
    end else begin
      r_rxd_d <= w_rxd_s;
      r_valid <= w_ok;
      r_ferr  <= w_ferr;
      r_brk   <= w_brk;
      if (w_ok) r_data <= r_shift;
      r_cnt <= r_cnt + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_bits   <= '0;
          r_lo_any <= 1'b0;
          r_lo_all <= 1'b1;
        end
        S_START:
          if (w_tick_half) r_cnt <= '0;
        S_RECV:
          if (w_tick_bit) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd_s, r_shift[PAYLOAD_BITS-1:1]};
            r_bits  <= w_last_bit ? '0 : r_bits + 1'b1;
          end
        S_STOP:
          if (w_tick_bit) begin
            r_cnt    <= '0;
            r_bits   <= r_bits + 1'b1;
            r_lo_any <= w_lo_any;
            r_lo_all <= w_lo_all;
          end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign uart_rx_valid     = r_valid;
  assign uart_rx_data      = r_data;
  assign uart_rx_frame_err = r_ferr;
  assign uart_rx_break     = r_brk;
endmodule
